// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the on-chip memory data port between two masters.
//   master 0 = CPU load/store, master 1 = UART loader / debug DMA.
// Ownership is registered and round-robin. One owner is served at a time,
// for at most MAX_BURST consecutive beats while the other master is waiting.
// Arbitration out of idle costs a one-cycle bubble. A hand-over between
// owners costs no bubble.
//
// Ports
//   clock, reset              : clock, asynchronous active-low reset
//   mX_req/addr/wdata/we      : master X single-beat request
//   mX_gnt                    : beat issued to memory this cycle (combinational)
//   mX_rvalid                 : read data for master X is on rdata this cycle
//   rdata                     : shared read data (mem_rdata pass-through)
//   mem_en/we/addr/wdata      : memory-side strobe, write enable, address, data
//   mem_rdata                 : memory read data, valid the cycle after a read
module mem_port_arbiter #(
  parameter int unsigned AW        = 16,
  parameter int unsigned DW        = 16,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          m0_req,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic          m0_we,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  input  logic          m1_req,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  input  logic          m1_we,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StOwn0 = 2'd1;
  localparam logic [1:0] StOwn1 = 2'd2;

  localparam logic [3:0] BurstLast = 4'(MAX_BURST - 1);

  logic [1:0] state_q, state_d;
  logic       last_q, last_d;
  logic [3:0] burst_cnt_q, burst_cnt_d;
  logic       rv0_q, rv0_d;
  logic       rv1_q, rv1_d;

  logic       own_id;
  logic       own_req;
  logic       oth_req;
  logic [1:0] oth_state;
  logic       burst_done;

  // Grants and the memory-side mux. Idle outputs are driven to zero so the
  // MMIO snoopers never see a stale address or data word.
  always_comb begin
    m0_gnt    = (state_q == StOwn0) & m0_req;
    m1_gnt    = (state_q == StOwn1) & m1_req;
    mem_en    = m0_gnt | m1_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (m0_gnt) begin
      mem_we    = m0_we;
      mem_addr  = m0_addr;
      mem_wdata = m0_wdata;
    end else if (m1_gnt) begin
      mem_we    = m1_we;
      mem_addr  = m1_addr;
      mem_wdata = m1_wdata;
    end
  end

  // Owner-relative view of the two masters; only meaningful in StOwn0/StOwn1.
  always_comb begin
    own_id    = (state_q == StOwn1);
    own_req   = own_id ? m1_req : m0_req;
    oth_req   = own_id ? m0_req : m1_req;
    oth_state = own_id ? StOwn0 : StOwn1;
    // '>=' also covers a count that ran past the limit while the other
    // master was quiet, so a late arrival still gets the port.
    burst_done = (burst_cnt_q >= BurstLast);
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    burst_cnt_d = burst_cnt_q;
    unique case (state_q)
      StIdle: begin
        burst_cnt_d = 4'd0;
        if (m0_req && m1_req) begin
          state_d = last_q ? StOwn0 : StOwn1;
        end else if (m0_req) begin
          state_d = StOwn0;
        end else if (m1_req) begin
          state_d = StOwn1;
        end
      end
      StOwn0, StOwn1: begin
        if (!own_req || (burst_done && oth_req)) begin
          last_d      = own_id;
          burst_cnt_d = 4'd0;
          state_d     = oth_req ? oth_state : StIdle;
        end else if (burst_cnt_q != 4'hF) begin
          burst_cnt_d = burst_cnt_q + 4'd1;
        end
      end
      default: begin
        state_d     = StIdle;
        burst_cnt_d = 4'd0;
      end
    endcase
  end

  // Read return: the beat's owner is remembered independently of the state
  // register, so a hand-over never disturbs an outstanding rvalid.
  always_comb begin
    rv0_d = m0_gnt & ~m0_we;
    rv1_d = m1_gnt & ~m1_we;
  end

  assign m0_rvalid = rv0_q;
  assign m1_rvalid = rv1_q;
  assign rdata     = mem_rdata;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      last_q      <= 1'b1;
      burst_cnt_q <= 4'd0;
      rv0_q       <= 1'b0;
      rv1_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      burst_cnt_q <= burst_cnt_d;
      rv0_q       <= rv0_d;
      rv1_q       <= rv1_d;
    end
  end

endmodule
